seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse of the convolution datapath's shift-add multiplier, with the same start/finish handshake.
- Produces quotient and remainder of a LEN-bit dividend by a LEN-bit divisor, one quotient bit per cycle.
- Used by convolution post-processing for averaging/normalisation; the controller drives start and samples results on finish.

Parameters:
- LEN, 32, operand/result width in bits (LEN >= 2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- dividend  in  LEN  unsigned dividend, sampled with start
- divisor  in  LEN  unsigned divisor, sampled with start
- start  in  1  request; honoured only in IDLE
- quotient  out  LEN  registered quotient
- remainder  out  LEN  registered remainder
- div_by_zero  out  1  result flag for divisor == 0, valid with finish and held until next accepted start
- busy  out  1  high in WORK and FINAL
- finish  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Reset values: state IDLE; quotient, remainder, internal divisor register and counter 0; div_by_zero 0; busy 0; finish 0.
- State machine states are IDLE, WORK and FINAL.
- IDLE:
  - On an edge with start=1 and divisor != 0: latch divisor, quo_reg<=dividend, rem_reg<=0, counter<=LEN-1, div_by_zero<=0, go to WORK.
  - On an edge with start=1 and divisor == 0: quotient<=all ones, remainder<=dividend, div_by_zero<=1, go directly to FINAL.
- WORK: one restoring step per edge.
  - shifted = {rem_reg[LEN-1:0], quo_reg[LEN-1]}, LEN+1 bits.
  - diff = shifted - {1'b0, divisor_reg}, LEN+1 bits.
  - If diff MSB = 0: rem_reg<=diff[LEN-1:0] and quo_reg<={quo_reg[LEN-2:0],1}.
  - Else: rem_reg<=shifted[LEN-1:0] and quo_reg<={quo_reg[LEN-2:0],0}.
  - Counter decrements each edge. On the edge where counter==0, perform the final step and go to FINAL.
  - Exactly LEN steps are performed.
- FINAL: finish=1 for exactly one cycle, then unconditionally back to IDLE. start is ignored in FINAL.
- Latency: for start sampled at edge E0, finish is high during the cycle after edge E(LEN), i.e. LEN cycles later. For divide-by-zero, finish is high in the cycle after E0.
- quotient/remainder are the quo_reg/rem_reg registers. Their values are guaranteed only while finish=1 and afterwards in IDLE. They hold the last result until the next accepted start. Intermediate values during WORK are not meaningful.
- start is ignored while busy. No queueing, no error.
- Operand changes after the accepted start have no effect.
- Special cases:
  - dividend < divisor: quotient 0, remainder = dividend.
  - divisor = 1: quotient = dividend, remainder 0.
- Reset asserted mid-operation aborts immediately to IDLE with reset values. No finish pulse is produced.
- Counter width is $clog2(LEN).

Decomposition:
- Shared package conv_pkg, alongside the existing convolution struct header, holds:
  - div_state_t enum {IDLE, WORK, FINAL}, 2 bits
  - localparam helper for counter width
- Optional sub-module div_step: combinational single restoring iteration (shifted/diff/select). Inputs rem, quo, divisor; outputs next rem and next quo. Reusable if the divider is later unrolled to 2 bits/cycle.
- Everything else stays in seq_divider.

Test Plan:
- LEN=32, dividend=100, divisor=7, one start pulse -> finish exactly 32 cycles after the start edge, quotient=14, remainder=2, div_by_zero=0, busy high for 33 cycles.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
- divisor=0, dividend=0x1234 -> finish in the cycle after the start edge, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1; the next valid division clears div_by_zero.
- Start 1000/10, re-pulse start with 77/3 mid-WORK and change operands -> only 100/0 result produced; no extra finish; second request ignored.
- Start 1000/10, assert rst at cycle 15 -> all outputs 0 in the same cycle, no finish pulse; a following 81/9 yields quotient 9, remainder 0.
- Random regression of 10k pairs with LEN=32 and LEN=8 -> results match / and % against a reference model; finish always exactly one cycle wide.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared convolution-datapath definitions: divider FSM states and the
// counter-width helper used by the sequential divider.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORK  = 2'd1,
    FINAL = 2'd2
  } div_state_t;

  // Step counter must hold LEN-1.
  function automatic int div_cnt_w(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, try a
// subtract, keep the difference only when it did not go negative.
module div_step #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] rem_i,
  input  logic [LEN-1:0] quo_i,
  input  logic [LEN-1:0] div_i,
  output logic [LEN-1:0] rem_o,
  output logic [LEN-1:0] quo_o
);

  logic [LEN:0] shifted;
  logic [LEN:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[LEN-1]};
    diff    = shifted - {1'b0, div_i};
    if (!diff[LEN]) begin
      rem_o = diff[LEN-1:0];
      quo_o = {quo_i[LEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[LEN-1:0];
      quo_o = {quo_i[LEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, with the
// same start/finish handshake as the shift-add multiplier.
module seq_divider
  import conv_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [LEN-1:0] dividend,
  input  logic [LEN-1:0] divisor,
  input  logic           start,
  output logic [LEN-1:0] quotient,
  output logic [LEN-1:0] remainder,
  output logic           div_by_zero,
  output logic           busy,
  output logic           finish
);

  localparam int CW = div_cnt_w(LEN);

  div_state_t     state_q, state_d;
  logic [LEN-1:0] quo_q, quo_d;
  logic [LEN-1:0] rem_q, rem_d;
  logic [LEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic [LEN-1:0] step_rem, step_quo;

  div_step #(.LEN(LEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvs_d   = divisor;
            quo_d   = dividend;
            rem_d   = '0;
            cnt_d   = CW'(LEN - 1);
            dz_d    = 1'b0;
            state_d = WORK;
          end else begin
            // Divide-by-zero skips the iterations and reports saturated quotient.
            quo_d   = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
            state_d = FINAL;
          end
        end
      end
      WORK: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FINAL;
      end
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
  assign busy        = (state_q != IDLE);
  assign finish      = (state_q == FINAL);

endmodule
